// File: rtl/video_timing_gen.sv
// Two-mode raster timing generator with ce-qualified counters, frame-aligned mode shadow and delayed sync/visible.
// Define VIDEO_TIMING_FRAME_COUNT_EN to add the frame_cnt output.
module video_timing_gen #(
  parameter int CW           = 11,
  parameter int SYNC_DELAY   = 0,
  parameter int M0_H_DISPLAY = 1024,
  parameter int M0_H_FRONT   = 24,
  parameter int M0_H_SYNC    = 136,
  parameter int M0_H_BACK    = 160,
  parameter int M0_V_DISPLAY = 768,
  parameter int M0_V_FRONT   = 3,
  parameter int M0_V_SYNC    = 6,
  parameter int M0_V_BACK    = 29,
  parameter int M1_H_DISPLAY = 640,
  parameter int M1_H_FRONT   = 16,
  parameter int M1_H_SYNC    = 96,
  parameter int M1_H_BACK    = 48,
  parameter int M1_V_DISPLAY = 480,
  parameter int M1_V_FRONT   = 10,
  parameter int M1_V_SYNC    = 2,
  parameter int M1_V_BACK    = 33,
  parameter int FC_W         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ce,
  input  logic          mode_req,
  input  logic          polarity,
  output logic          mode_active,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  ,
  output logic [FC_W-1:0] frame_cnt
`endif
);

  localparam logic [CW-1:0] M0_HD  = CW'(M0_H_DISPLAY);
  localparam logic [CW-1:0] M0_HSS = CW'(M0_H_DISPLAY + M0_H_FRONT);
  localparam logic [CW-1:0] M0_HSE = CW'(M0_H_DISPLAY + M0_H_FRONT + M0_H_SYNC - 1);
  localparam logic [CW-1:0] M0_HMX = CW'(M0_H_DISPLAY + M0_H_FRONT + M0_H_SYNC + M0_H_BACK - 1);
  localparam logic [CW-1:0] M0_VD  = CW'(M0_V_DISPLAY);
  localparam logic [CW-1:0] M0_VSS = CW'(M0_V_DISPLAY + M0_V_FRONT);
  localparam logic [CW-1:0] M0_VSE = CW'(M0_V_DISPLAY + M0_V_FRONT + M0_V_SYNC - 1);
  localparam logic [CW-1:0] M0_VMX = CW'(M0_V_DISPLAY + M0_V_FRONT + M0_V_SYNC + M0_V_BACK - 1);
  localparam logic [CW-1:0] M1_HD  = CW'(M1_H_DISPLAY);
  localparam logic [CW-1:0] M1_HSS = CW'(M1_H_DISPLAY + M1_H_FRONT);
  localparam logic [CW-1:0] M1_HSE = CW'(M1_H_DISPLAY + M1_H_FRONT + M1_H_SYNC - 1);
  localparam logic [CW-1:0] M1_HMX = CW'(M1_H_DISPLAY + M1_H_FRONT + M1_H_SYNC + M1_H_BACK - 1);
  localparam logic [CW-1:0] M1_VD  = CW'(M1_V_DISPLAY);
  localparam logic [CW-1:0] M1_VSS = CW'(M1_V_DISPLAY + M1_V_FRONT);
  localparam logic [CW-1:0] M1_VSE = CW'(M1_V_DISPLAY + M1_V_FRONT + M1_V_SYNC - 1);
  localparam logic [CW-1:0] M1_VMX = CW'(M1_V_DISPLAY + M1_V_FRONT + M1_V_SYNC + M1_V_BACK - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic ls;
    logic fs;
  } stage_t;

  logic [CW-1:0] h_disp, h_ss, h_se, h_max;
  logic [CW-1:0] v_disp, v_ss, v_se, v_max;
  logic          line_wrap, frame_wrap, clear;
  stage_t        s0;
  stage_t        pipe [SYNC_DELAY+1];
  stage_t        tail;

  always_comb begin
    h_disp = mode_active ? M1_HD  : M0_HD;
    h_ss   = mode_active ? M1_HSS : M0_HSS;
    h_se   = mode_active ? M1_HSE : M0_HSE;
    h_max  = mode_active ? M1_HMX : M0_HMX;
    v_disp = mode_active ? M1_VD  : M0_VD;
    v_ss   = mode_active ? M1_VSS : M0_VSS;
    v_se   = mode_active ? M1_VSE : M0_VSE;
    v_max  = mode_active ? M1_VMX : M0_VMX;
  end

  assign clear      = reset || !enable;
  assign line_wrap  = (pix_x == h_max);
  assign frame_wrap = line_wrap && (pix_y == v_max);

  // Mode is only re-sampled on the last pixel of a frame, so limits never change mid-frame.
  always_ff @(posedge clk) begin
    if (clear) begin
      pix_x       <= '0;
      pix_y       <= '0;
      mode_active <= mode_req;
    end else if (ce) begin
      if (line_wrap) begin
        pix_x <= '0;
        pix_y <= (pix_y == v_max) ? '0 : pix_y + 1'b1;
      end else begin
        pix_x <= pix_x + 1'b1;
      end
      if (frame_wrap)
        mode_active <= mode_req;
    end
  end

  always_comb begin
    s0     = '0;
    s0.hs  = (pix_x >= h_ss) && (pix_x <= h_se);
    s0.vs  = (pix_y >= v_ss) && (pix_y <= v_se);
    s0.vis = (pix_x < h_disp) && (pix_y < v_disp);
    s0.ls  = (pix_x == '0);
    s0.fs  = (pix_x == '0) && (pix_y == '0);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < SYNC_DELAY + 1; i++)
        pipe[i] <= '0;
    end else if (ce) begin
      pipe[0] <= s0;
      for (int unsigned i = 1; i < SYNC_DELAY + 1; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail        = pipe[SYNC_DELAY];
  assign hsync       = tail.hs ^ ~polarity;
  assign vsync       = tail.vs ^ ~polarity;
  assign visible     = tail.vis & enable;
  assign line_start  = tail.ls & ce;
  assign frame_start = tail.fs & ce;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (clear)
      frame_cnt <= '0;
    else if (ce && frame_wrap)
      frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule
